// File: rtl/vic_pkg.sv
// Shared VIC constants and types: register-file geometry, source count, dispatcher states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vic_pkg;

  // Register-file geometry, shared with the VIC configuration register file.
  localparam int CONFREG_WIDTH = 4;
  localparam int ARRAY_LENGTH  = 32;
  localparam int ENA_INDEX     = 31;

  // One register-file entry per source, plus the global enable entry.
  localparam int NUM_SRC    = ARRAY_LENGTH - 1;
  localparam int PRIO_WIDTH = CONFREG_WIDTH;
  localparam int ID_WIDTH   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } vic_state_e;

endpackage

// File: rtl/vic_prio_tree.sv
// Picks the highest-priority eligible source; ties go to the lowest index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is recomputed from the inputs every cycle.
//   eligible_i : per-source eligibility (pending, unmasked, globally enabled)
//   prio_i     : packed priorities, source i at [4i+3:4i]
//   valid_o/id_o/prio_o : winner present, its index and its priority
module vic_prio_tree
  import vic_pkg::*;
(
  input  logic [NUM_SRC-1:0]            eligible_i,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio_i,
  output logic                          valid_o,
  output logic [ID_WIDTH-1:0]           id_o,
  output logic [PRIO_WIDTH-1:0]         prio_o
);

  logic                  best_vld;
  logic [ID_WIDTH-1:0]   best_id;
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [PRIO_WIDTH-1:0] cand;

  // Scanning upward with a strict compare keeps the earliest (lowest) index
  // on equal priorities.
  always_comb begin
    best_vld  = 1'b0;
    best_id   = '0;
    best_prio = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
      if (eligible_i[i] && (!best_vld || (cand > best_prio))) begin
        best_vld  = 1'b1;
        best_id   = ID_WIDTH'(i);
        best_prio = cand;
      end
    end
  end

  assign valid_o = best_vld;
  assign id_o    = best_id;
  assign prio_o  = best_prio;

endmodule

// File: rtl/vic_priority_dispatcher.sv
// Captures interrupt edges, selects the top eligible source and runs the offer/ack/eoi handshake.
// Latency: edge -> pending 1 cycle, -> best 2 cycles, -> o_irq 3 cycles; config change -> o_irq 2 cycles.
// Backpressure: an offer is held until i_ack; no new offer is made while a source is in service.
//   clk, rst (async, active-low)
//   i_irq       : level request lines, rising edge sets pending
//   i_buffer    : per-source priorities (0 = masked), i_enable : global enable
//   i_ack/i_eoi : CPU acknowledge / end-of-interrupt
//   o_irq, o_irq_id, o_irq_prio, o_active, o_pending : registered status to the CPU
module vic_priority_dispatcher
  import vic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            i_irq,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] i_buffer,
  input  logic                          i_enable,
  input  logic                          i_ack,
  input  logic                          i_eoi,
  output logic                          o_irq,
  output logic [ID_WIDTH-1:0]           o_irq_id,
  output logic [PRIO_WIDTH-1:0]         o_irq_prio,
  output logic                          o_active,
  output logic [NUM_SRC-1:0]            o_pending
);

  logic [NUM_SRC-1:0]    irq_q;
  logic                  cap_en_q;
  logic [NUM_SRC-1:0]    pending_q, pending_d;
  logic [NUM_SRC-1:0]    edge_set, ack_clr, eligible;

  logic                  tree_vld;
  logic [ID_WIDTH-1:0]   tree_id;
  logic [PRIO_WIDTH-1:0] tree_prio;
  logic                  best_valid_q;
  logic [ID_WIDTH-1:0]   best_id_q;
  logic [PRIO_WIDTH-1:0] best_prio_q;

  vic_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [PRIO_WIDTH-1:0] prio_q, prio_d;
  logic                  irq_out_q, active_q;
  logic                  ack_take;

  // cap_en_q stays low for the first clock after reset so that a line already
  // high at release only loads irq_q and is not mistaken for a rising edge.
  assign edge_set  = i_irq & ~irq_q & {NUM_SRC{cap_en_q}};
  assign ack_clr   = ack_take ? (NUM_SRC'(1) << id_q) : '0;
  // A new edge on the source being acknowledged wins over the clear.
  assign pending_d = (pending_q & ~ack_clr) | edge_set;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending_q[i] && (i_buffer[i*PRIO_WIDTH +: PRIO_WIDTH] != '0) && i_enable;
    end
  end

  vic_prio_tree u_prio_tree (
    .eligible_i (eligible),
    .prio_i     (i_buffer),
    .valid_o    (tree_vld),
    .id_o       (tree_id),
    .prio_o     (tree_prio)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    prio_d   = prio_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (best_valid_q) begin
          state_d = OFFER;
          id_d    = best_id_q;
          prio_d  = best_prio_q;
        end
      end
      OFFER: begin
        // Ack refers to whatever is on o_irq_id now, so it beats withdraw/re-latch.
        if (i_ack) begin
          ack_take = 1'b1;
          state_d  = SERVICE;
        end else if (!best_valid_q) begin
          state_d = IDLE;
        end else if (best_prio_q > prio_q) begin
          id_d   = best_id_q;
          prio_d = best_prio_q;
        end
      end
      SERVICE: begin
        if (i_eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q        <= '0;
      cap_en_q     <= 1'b0;
      pending_q    <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      state_q      <= IDLE;
      id_q         <= '0;
      prio_q       <= '0;
      irq_out_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      irq_q        <= i_irq;
      cap_en_q     <= 1'b1;
      pending_q    <= pending_d;
      best_valid_q <= tree_vld;
      best_id_q    <= tree_id;
      best_prio_q  <= tree_prio;
      state_q      <= state_d;
      id_q         <= id_d;
      prio_q       <= prio_d;
      irq_out_q    <= (state_d == OFFER);
      active_q     <= (state_d == SERVICE);
    end
  end

  assign o_irq      = irq_out_q;
  assign o_irq_id   = id_q;
  assign o_irq_prio = prio_q;
  assign o_active   = active_q;
  assign o_pending  = pending_q;

endmodule

// File: tb/tb_vic_priority_dispatcher.sv
// Directed bench for vic_priority_dispatcher with hand-computed expectations.
// Latency: checks exact cycle timing of offer, ack, eoi, config change and reset.
// Backpressure: n/a; every wait on the DUT is cycle-bounded.
module tb_vic_priority_dispatcher;
  import vic_pkg::*;

  logic                          clk;
  logic                          rst;
  logic [NUM_SRC-1:0]            i_irq;
  logic [NUM_SRC*PRIO_WIDTH-1:0] i_buffer;
  logic                          i_enable;
  logic                          i_ack;
  logic                          i_eoi;
  logic                          o_irq;
  logic [ID_WIDTH-1:0]           o_irq_id;
  logic [PRIO_WIDTH-1:0]         o_irq_prio;
  logic                          o_active;
  logic [NUM_SRC-1:0]            o_pending;

  int n_tests = 0;
  int n_fail  = 0;

  vic_priority_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .i_irq      (i_irq),
    .i_buffer   (i_buffer),
    .i_enable   (i_enable),
    .i_ack      (i_ack),
    .i_eoi      (i_eoi),
    .o_irq      (o_irq),
    .o_irq_id   (o_irq_id),
    .o_irq_prio (o_irq_prio),
    .o_active   (o_active),
    .o_pending  (o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int idx, input logic [3:0] val);
    i_buffer[idx*PRIO_WIDTH +: PRIO_WIDTH] = val;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] mask);
    i_irq = i_irq | mask;
    tick();
    i_irq = i_irq & ~mask;
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic do_eoi();
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!o_irq && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, o_irq}, 32'd1);
  endtask

  function automatic logic [NUM_SRC-1:0] bit_of(input int idx);
    logic [NUM_SRC-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  initial begin
    rst      = 1'b0;
    i_irq    = '0;
    i_buffer = '0;
    i_enable = 1'b0;
    i_ack    = 1'b0;
    i_eoi    = 1'b0;

    // Reset state
    #12;
    chk("rst_irq",     {31'd0, o_irq}, 32'd0);
    chk("rst_id",      {27'd0, o_irq_id}, 32'd0);
    chk("rst_prio",    {28'd0, o_irq_prio}, 32'd0);
    chk("rst_active",  {31'd0, o_active}, 32'd0);
    chk("rst_pending", {1'b0, o_pending}, 32'd0);
    rst = 1'b1;
    repeat (3) tick();

    // 1. Single source, exact latency
    set_prio(3, 4'd5);
    i_enable = 1'b1;
    pulse(bit_of(3));
    chk("s1_pend_set", {1'b0, o_pending}, 32'h8);
    chk("s1_irq_k",    {31'd0, o_irq}, 32'd0);
    tick();
    chk("s1_irq_k1",   {31'd0, o_irq}, 32'd0);
    tick();
    chk("s1_irq_k2",   {31'd0, o_irq}, 32'd1);
    chk("s1_id",       {27'd0, o_irq_id}, 32'd3);
    chk("s1_prio",     {28'd0, o_irq_prio}, 32'd5);
    do_ack();
    chk("s1_ack_irq",  {31'd0, o_irq}, 32'd0);
    chk("s1_active",   {31'd0, o_active}, 32'd1);
    chk("s1_pend_clr", {1'b0, o_pending}, 32'd0);
    do_eoi();
    chk("s1_eoi_act",  {31'd0, o_active}, 32'd0);
    repeat (3) tick();
    chk("s1_idle_irq", {31'd0, o_irq}, 32'd0);

    // 2. Priority ordering with tie to lowest index
    i_buffer = '0;
    set_prio(2, 4'd9);
    set_prio(7, 4'd9);
    set_prio(4, 4'd6);
    pulse(bit_of(2) | bit_of(7) | bit_of(4));
    wait_irq("s2_irq_a", 10);
    chk("s2_id_a",   {27'd0, o_irq_id}, 32'd2);
    chk("s2_prio_a", {28'd0, o_irq_prio}, 32'd9);
    do_ack();
    chk("s2_pend_a", {1'b0, o_pending}, 32'h90);
    do_eoi();
    chk("s2_gap",    {31'd0, o_irq}, 32'd0);
    tick();
    chk("s2_irq_b",  {31'd0, o_irq}, 32'd1);
    chk("s2_id_b",   {27'd0, o_irq_id}, 32'd7);
    do_ack();
    do_eoi();
    wait_irq("s2_irq_c", 10);
    chk("s2_id_c",   {27'd0, o_irq_id}, 32'd4);
    chk("s2_prio_c", {28'd0, o_irq_prio}, 32'd6);
    do_ack();
    do_eoi();
    chk("s2_pend_end", {1'b0, o_pending}, 32'd0);

    // 3. Preemption while offering
    i_buffer = '0;
    set_prio(1, 4'd3);
    set_prio(10, 4'd12);
    pulse(bit_of(1));
    wait_irq("s3_irq", 10);
    chk("s3_id_a", {27'd0, o_irq_id}, 32'd1);
    pulse(bit_of(10));
    tick();
    chk("s3_hold_id", {27'd0, o_irq_id}, 32'd1);
    tick();
    chk("s3_pre_irq",  {31'd0, o_irq}, 32'd1);
    chk("s3_pre_id",   {27'd0, o_irq_id}, 32'd10);
    chk("s3_pre_prio", {28'd0, o_irq_prio}, 32'd12);
    do_ack();
    chk("s3_pend", {1'b0, o_pending}, 32'h2);
    do_eoi();
    wait_irq("s3_irq_b", 10);
    chk("s3_id_b", {27'd0, o_irq_id}, 32'd1);
    do_ack();
    do_eoi();

    // 4. Masking and enable withdrawal
    i_buffer = '0;
    pulse(bit_of(5));
    repeat (3) tick();
    chk("s4_pend_mask", {1'b0, o_pending}, 32'h20);
    chk("s4_irq_mask",  {31'd0, o_irq}, 32'd0);
    set_prio(5, 4'd4);
    tick();
    chk("s4_cfg_1", {31'd0, o_irq}, 32'd0);
    tick();
    chk("s4_cfg_2", {31'd0, o_irq}, 32'd1);
    chk("s4_id",    {27'd0, o_irq_id}, 32'd5);
    chk("s4_prio",  {28'd0, o_irq_prio}, 32'd4);
    i_enable = 1'b0;
    tick();
    chk("s4_dis_1", {31'd0, o_irq}, 32'd1);
    tick();
    chk("s4_dis_2", {31'd0, o_irq}, 32'd0);
    chk("s4_pend_kept", {1'b0, o_pending}, 32'h20);
    i_enable = 1'b1;
    wait_irq("s4_reoffer", 10);
    do_ack();
    do_eoi();

    // 5. Ack coinciding with a new edge on the same source; level hold
    i_buffer = '0;
    set_prio(6, 4'd7);
    pulse(bit_of(6));
    wait_irq("s5_irq", 10);
    i_irq = bit_of(6);
    do_ack();
    chk("s5_active", {31'd0, o_active}, 32'd1);
    chk("s5_pend",   {1'b0, o_pending}, 32'h40);
    do_eoi();
    wait_irq("s5_irq_b", 10);
    chk("s5_id_b", {27'd0, o_irq_id}, 32'd6);
    do_ack();
    chk("s5_level_1", {1'b0, o_pending}, 32'd0);
    repeat (2) tick();
    chk("s5_level_2", {1'b0, o_pending}, 32'd0);
    do_eoi();
    i_irq = '0;
    tick();

    // 6. Async reset in SERVICE; line held high across release
    i_buffer = '0;
    set_prio(8, 4'd2);
    set_prio(9, 4'd1);
    pulse(bit_of(8) | bit_of(9));
    wait_irq("s6_irq", 10);
    chk("s6_id", {27'd0, o_irq_id}, 32'd8);
    do_ack();
    chk("s6_svc", {31'd0, o_active}, 32'd1);
    chk("s6_pend_pre", {1'b0, o_pending}, 32'h200);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_rst_active", {31'd0, o_active}, 32'd0);
    chk("s6_rst_pend",   {1'b0, o_pending}, 32'd0);
    chk("s6_rst_id",     {27'd0, o_irq_id}, 32'd0);
    i_irq = bit_of(9);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    repeat (3) tick();
    chk("s6_hold_pend", {1'b0, o_pending}, 32'd0);
    chk("s6_hold_irq",  {31'd0, o_irq}, 32'd0);
    i_irq = '0;
    tick();
    pulse(bit_of(9));
    chk("s6_new_edge", {1'b0, o_pending}, 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vic_priority_dispatcher.md
# vic_priority_dispatcher

Interrupt selection stage directly downstream of the VIC configuration register file. It captures rising edges on 31 peripheral interrupt lines and applies the per-source 4-bit priorities and the global enable from the register file. It presents the single highest-priority pending source to the CPU and tracks it through an acknowledge / end-of-interrupt handshake.

## Interface
- NUM_SRC, 31: number of interrupt sources. Equals register-file entries minus the enable entry.
- PRIO_WIDTH, 4: priority field width. Equals the configuration register width.
- ID_WIDTH, 5: source index width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  **one clock; reset is asynchronous and active-low**.
- i_irq  in  NUM_SRC  level request lines, synchronous to clk; bit i = source i.
- i_buffer  in  NUM_SRC*PRIO_WIDTH  priorities from the register file; source i at bits [4i+3:4i]. Value 0 = masked.
- i_enable  in  1  global enable from the register file.
- i_ack  in  1  CPU accepts the offered interrupt.
- i_eoi  in  1  CPU finished servicing.
- o_irq  out  1  interrupt request to CPU.
- o_irq_id  out  ID_WIDTH  offered/active source index.
- o_irq_prio  out  PRIO_WIDTH  offered/active priority.
- o_active  out  1  in service (between ack and eoi).
- o_pending  out  NUM_SRC  pending flags.

## Operation
- Edge capture: the block registers i_irq as irq_q each cycle. pending[i] is set when i_irq[i] & ~irq_q[i]. pending[i] is cleared when source i is acknowledged. If set and clear occur in the same cycle, set wins.
- Pending capture is independent of i_enable and priority. A masked source stays pending until acknowledged.
- Eligible[i] = pending[i] & (prio[i] != 0) & i_enable.
- Selection: take the maximum prio over the eligible sources. Ties go to the lowest index. Each cycle the result is registered into best_valid, best_id and best_prio.
- FSM states: IDLE, OFFER, SERVICE.
  - IDLE: o_irq=0, o_active=0. If best_valid, latch best_id/best_prio into o_irq_id/o_irq_prio and go to OFFER.
  - OFFER: o_irq=1.
    - If i_ack: clear pending[o_irq_id] and go to SERVICE.
    - Otherwise, if !best_valid (enable dropped, source masked): go to IDLE and withdraw the offer. pending is not cleared.
    - Otherwise, if best_prio > o_irq_prio (strictly greater): re-latch id and prio and stay in OFFER.
    - i_ack takes precedence over withdraw and re-latch in the same cycle. The source acknowledged is the one shown on o_irq_id in that cycle.
  - SERVICE: o_irq=0, o_active=1, id/prio held. On i_eoi go to IDLE. i_enable and priority changes are ignored. No nesting.
- i_ack outside OFFER and i_eoi outside SERVICE are ignored.

## Timing
- Reset values: o_irq=0, o_irq_id=0, o_irq_prio=0, o_active=0, o_pending=0, irq_q=0, state IDLE. All outputs are registered.
- Latency: i_irq rises before edge k → pending set at edge k → best registered at edge k+1 → o_irq=1 after edge k+2.
- Ack: i_ack high at edge n → o_irq=0, o_active=1, pending bit cleared, all after edge n.
- Eoi: i_eoi at edge n → IDLE after edge n. If another source is already eligible, the next offer appears after edge n+1.
- A configuration change (priority or enable) affects best after one cycle and o_irq after two.
- Asserting rst mid-operation drops the offer, the service state and all pending flags immediately. No edges are captured while in reset. A line held high through reset release is not treated as an edge, because irq_q loads the high line on the first clock.

## Structure
- Shared package vic_pkg holds:
  - CONFREG_WIDTH=4, ARRAY_LENGTH=32, ENA_INDEX=31 (shared with the register file).
  - NUM_SRC, ID_WIDTH.
  - The state enum {IDLE, OFFER, SERVICE}.
- One sub-module, vic_prio_tree: a purely combinational max-with-lowest-index-tie tree. Its inputs are eligible and the priorities; its outputs are valid, id and prio. The dispatcher registers its outputs.

## Test plan
- Single source: prio[3]=5, enable=1, pulse i_irq[3] → o_irq=1, id=3, prio=5 two cycles later. i_ack → o_active=1, pending[3]=0. i_eoi → IDLE, o_irq stays 0.
- Priority and tie: sources 2 and 7 both at prio 9, source 4 at prio 6, all pulsed together → offered in order 2, then 7, then 4 across ack/eoi cycles.
- Preemption in OFFER: source 1 at prio 3 offered; pulse source 10 at prio 12 before ack → o_irq_id becomes 10, o_irq_prio 12, o_irq stays 1. Ack → pending[1] still set.
- Masking: prio[5]=0, pulse i_irq[5] → pending[5]=1, o_irq=0. Write prio 4 → o_irq=1 with id=5 two cycles later. Drop enable during OFFER → o_irq=0, pending[5] still 1.
- Same-cycle events: i_ack coincides with a new i_irq edge on the same source → pending stays 1, state goes to SERVICE. Level held high without new edge → no re-capture.
- Async reset asserted in SERVICE with pending bits set → all outputs 0 immediately. Line held high across release → no pending set.
